gate_bist_checker: RTL and testbench

//   Synthesizable built-in self-test sequencer for any 2-input logic gate (and_gate_p, or, xor, ...).
//   It is the response end of the gate-test interface:
//   - drives the gate inputs a/b through all four truth-table vectors;
//   - samples the gate output c after a settle delay and compares it with an expected truth table;
//   - reports pass/fail, the mismatch count and the first failing vector.

---
 rtl/gate_bist_checker.sv | 151 +++++++++++++++
 tb/tb_gate_bist_checker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gate_bist_checker.sv
// gate_bist_checker
// BIST sequencer for a 2-input logic gate. It walks the gate inputs {a,b}
// through 00, 01, 10, 11, lets each vector settle for SETTLE_CYC cycles,
// samples the gate output c once per vector and compares it with GATE_TT.
// It reports pass/fail, the mismatch count and the first failing vector.
// All outputs come straight from registers.

module gate_bist_checker #(
    parameter logic [3:0]  GATE_TT    = 4'b1000,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       c,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [1:0] fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // With no settle time, a new vector is checked in the very next cycle.
    localparam state_t ENTRY_ST = (SETTLE_CYC == 0) ? ST_CHECK : ST_SETTLE;

    // Last value of the wait counter before moving to CHECK.
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

    state_t     state_r;
    logic [1:0] idx_r;
    logic [3:0] wait_r;
    logic       a_r;
    logic       b_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [2:0] err_cnt_r;
    logic [1:0] fail_vec_r;

    logic       mismatch_s;
    logic [2:0] err_next_s;
    logic [1:0] idx_next_s;

    // Compare the sampled gate output with the expected truth-table bit and
    // form the error count this vector would leave behind.
    always_comb begin
        mismatch_s = 1'b0;
        err_next_s = err_cnt_r;
        idx_next_s = idx_r + 2'd1;
        if (c != GATE_TT[idx_r]) begin
            mismatch_s = 1'b1;
            if (err_cnt_r != 3'd4) begin
                err_next_s = err_cnt_r + 3'd1;
            end else begin
                err_next_s = err_cnt_r;
            end
        end else begin
            mismatch_s = 1'b0;
            err_next_s = err_cnt_r;
        end
    end

    // Test sequencer: state, vector index, settle counter and all results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= 2'd0;
            wait_r     <= 4'd0;
            a_r        <= 1'b0;
            b_r        <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_cnt_r  <= 3'd0;
            fail_vec_r <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // start is only honoured here; results are cleared on the start edge.
                    if (start) begin
                        state_r    <= ENTRY_ST;
                        idx_r      <= 2'd0;
                        wait_r     <= 4'd0;
                        a_r        <= 1'b0;
                        b_r        <= 1'b0;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        pass_r     <= 1'b0;
                        err_cnt_r  <= 3'd0;
                        fail_vec_r <= 2'd0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_SETTLE: begin
                    if (wait_r == SETTLE_LAST) begin
                        wait_r  <= 4'd0;
                        state_r <= ST_CHECK;
                    end else begin
                        wait_r  <= wait_r + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch_s) begin
                        err_cnt_r <= err_next_s;
                        if (err_cnt_r == 3'd0) begin
                            fail_vec_r <= idx_r;
                        end else begin
                            fail_vec_r <= fail_vec_r;
                        end
                    end else begin
                        err_cnt_r <= err_cnt_r;
                    end
                    if (idx_r != 2'd3) begin
                        idx_r   <= idx_next_s;
                        a_r     <= idx_next_s[1];
                        b_r     <= idx_next_s[0];
                        wait_r  <= 4'd0;
                        state_r <= ENTRY_ST;
                    end else begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        pass_r  <= (err_next_s == 3'd0);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign a        = a_r;
    assign b        = b_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;
    assign err_cnt  = err_cnt_r;
    assign fail_vec = fail_vec_r;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Testbench for gate_bist_checker. Three instances: default parameters,
// an OR-expecting table, and zero settle time. The gate under test is
// modelled by a truth table chosen per run (directed or random); expected
// results come from counting and locating differing truth-table bits.

module tb_gate_bist_checker;

    logic clk = 1'b0;
    logic rst, start, start2;
    logic c0, c1, c2;
    logic a0, b0, busy0, done0, pass0;
    logic a1, b1, busy1, done1, pass1;
    logic a2, b2, busy2, done2, pass2;
    logic [2:0] err0, err1, err2;
    logic [1:0] fv0, fv1, fv2;

    logic [3:0] tt0, tt1, tt2;
    logic       xmode;
    logic [1:0] ab_d1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    gate_bist_checker #(.GATE_TT(4'b1000), .SETTLE_CYC(2)) u0 (
        .clk(clk), .rst(rst), .start(start), .c(c0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fv0));

    gate_bist_checker #(.GATE_TT(4'b1110), .SETTLE_CYC(2)) u1 (
        .clk(clk), .rst(rst), .start(start), .c(c1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1));

    gate_bist_checker #(.GATE_TT(4'b1000), .SETTLE_CYC(0)) u2 (
        .clk(clk), .rst(rst), .start(start2), .c(c2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_vec(fv2));

    // Remember the previous vector so u0's gate can glitch right after a change.
    always @(posedge clk) ab_d1 <= {a0, b0};

    // Gate models: output is the truth-table bit; u0's inverts while settling in xmode.
    assign c0 = (xmode && ({a0, b0} != ab_d1)) ? ~tt0[{a0, b0}] : tt0[{a0, b0}];
    assign c1 = tt1[{a1, b1}];
    assign c2 = tt2[{a2, b2}];

    function automatic logic [2:0] m_err(input logic [3:0] gate, input logic [3:0] expd);
        int n = 0;
        for (int i = 0; i < 4; i++) if (gate[i] != expd[i]) n++;
        return 3'(n);
    endfunction

    function automatic logic [1:0] m_fv(input logic [3:0] gate, input logic [3:0] expd);
        for (int i = 0; i < 4; i++) if (gate[i] != expd[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic chk_results0(input string tag, input logic [3:0] t);
        chk({tag, "_done0"}, 32'(done0), 32'd1);
        chk({tag, "_busy0"}, 32'(busy0), 32'd0);
        chk({tag, "_err0"},  32'(err0),  32'(m_err(t, 4'b1000)));
        chk({tag, "_fv0"},   32'(fv0),   32'(m_fv(t, 4'b1000)));
        chk({tag, "_pass0"}, 32'(pass0), 32'(m_err(t, 4'b1000) == 3'd0));
        chk({tag, "_ab0"},   32'({a0, b0}), 32'd3);
    endtask

    // One run of u0/u1 with settle 2: checks the vector walk and final results.
    task automatic run01(input logic [3:0] t0, input logic [3:0] t1, input bit xm, input bit poke);
        int v;
        tt0 = t0; tt1 = t1; xmode = xm;
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            start = (poke && k == 3);
            v = k / 3;
            chk("walk_ab", 32'({a0, b0}), 32'(v));
            chk("run_busy", 32'(busy0), 32'd1);
            chk("run_done", 32'(done0), 32'd0);
        end
        start = 1'b0;
        @(negedge clk);
        chk_results0("end", t0);
        chk("end_done1", 32'(done1), 32'd1);
        chk("end_err1",  32'(err1),  32'(m_err(t1, 4'b1110)));
        chk("end_fv1",   32'(fv1),   32'(m_fv(t1, 4'b1110)));
        chk("end_pass1", 32'(pass1), 32'(m_err(t1, 4'b1110) == 3'd0));
    endtask

    // One run of u2 with zero settle: one cycle per vector.
    task automatic run2(input logic [3:0] t2);
        tt2 = t2;
        @(negedge clk); start2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            chk("s0_ab", 32'({a2, b2}), 32'(k));
            chk("s0_busy", 32'(busy2), 32'd1);
            chk("s0_done", 32'(done2), 32'd0);
        end
        @(negedge clk);
        chk("s0_done_end", 32'(done2), 32'd1);
        chk("s0_err", 32'(err2), 32'(m_err(t2, 4'b1000)));
        chk("s0_fv",  32'(fv2),  32'(m_fv(t2, 4'b1000)));
        chk("s0_pass", 32'(pass2), 32'(m_err(t2, 4'b1000) == 3'd0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        tt0 = 4'b1000; tt1 = 4'b1110; tt2 = 4'b1000; xmode = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ab", 32'({a0, b0}), 32'd0);
        chk("rst_flags", 32'({busy0, done0, pass0}), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_fv", 32'(fv0), 32'd0);
        chk("rst_u2", 32'({busy2, done2, pass2, err2, fv2}), 32'd0);
        rst = 1'b0;

        // Directed: AND/OR correct, stuck-at-0, OR against AND table, all wrong.
        run01(4'b1000, 4'b1110, 1'b0, 1'b0);
        run01(4'b0000, 4'b0000, 1'b0, 1'b0);
        run01(4'b1110, 4'b1110, 1'b0, 1'b0);
        run01(4'b0111, 4'b0001, 1'b0, 1'b0);
        // start during a run is ignored; glitches while settling are ignored.
        run01(4'b0110, 4'b1110, 1'b1, 1'b1);

        // Reset mid-run discards everything on the next edge.
        tt0 = 4'b0000;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ab", 32'({a0, b0}), 32'd0);
        chk("midrst_flags", 32'({busy0, done0, pass0}), 32'd0);
        chk("midrst_res", 32'({err0, fv0}), 32'd0);
        // Reset together with start: reset wins.
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rststart_busy", 32'(busy0), 32'd0);
        @(negedge clk);
        chk("rststart_idle", 32'({busy0, done0}), 32'd0);
        run01(4'b1000, 4'b1110, 1'b0, 1'b0);

        // Zero settle: failing run then clean run clears the old errors.
        run2(4'b1000);
        run2(4'b0101);
        run2(4'b1000);

        // start held high: done lasts one cycle then a new run begins.
        tt2 = 4'b1001;
        @(negedge clk); start2 = 1'b1;
        repeat (4) @(negedge clk);
        chk("hold_busy", 32'(busy2), 32'd1);
        @(negedge clk);
        chk("hold_done", 32'(done2), 32'd1);
        chk("hold_err", 32'(err2), 32'(m_err(4'b1001, 4'b1000)));
        @(negedge clk);
        start2 = 1'b0;
        chk("hold_pulse", 32'({busy2, done2}), 32'b10);
        chk("hold_clr", 32'(err2), 32'd0);
        repeat (4) @(negedge clk);
        chk("hold_end", 32'(done2), 32'd1);
        chk("hold_fv", 32'(fv2), 32'(m_fv(4'b1001, 4'b1000)));

        // Randomized truth tables for the gate under test.
        for (int r = 0; r < 10; r++) begin
            run01(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run2(4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
